// File: rtl/fetch_unit_bp_pkg.sv
// rtl/fetch_unit_bp_pkg.sv - opcodes, fetch state encoding and immediate decoders
package fetch_unit_bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    ST_FETCH    = 1'b0,
    ST_WAIT_RDR = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  // x1/x5 are the link registers used for call/return hinting
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/fetch_unit_bp_if.sv
// rtl/fetch_unit_bp_if.sv - icache, dispatch, redirect and training signals of the fetch stage
interface fetch_unit_bp_if #(
  parameter int BHT_IDX_W = 5,
  parameter int GHR_W     = 0
);
  localparam int GW = (GHR_W > 0) ? GHR_W : 1;

  logic                 rdy;
  logic                 icache_hit;
  logic [31:0]          icache_ins;
  logic [31:0]          icache_addr;
  logic                 rs_full;
  logic                 rob_full;
  logic                 lsb_full;
  logic                 issue_en;
  logic [31:0]          issue_pc;
  logic [31:0]          issue_ins;
  logic                 issue_pred_tk;
  logic [31:0]          issue_pred_pc;
  logic [BHT_IDX_W-1:0] issue_bht_idx;
  logic [GW-1:0]        issue_ghr;
  logic                 clear;
  logic [31:0]          new_pc;
  logic [GW-1:0]        clear_ghr;
  logic                 upt_en;
  logic [BHT_IDX_W-1:0] upt_idx;
  logic                 upt_taken;

  modport master (
    input  rdy, icache_hit, icache_ins, rs_full, rob_full, lsb_full,
           clear, new_pc, clear_ghr, upt_en, upt_idx, upt_taken,
    output icache_addr, issue_en, issue_pc, issue_ins, issue_pred_tk,
           issue_pred_pc, issue_bht_idx, issue_ghr
  );

  modport slave (
    output rdy, icache_hit, icache_ins, rs_full, rob_full, lsb_full,
           clear, new_pc, clear_ghr, upt_en, upt_idx, upt_taken,
    input  icache_addr, issue_en, issue_pc, issue_ins, issue_pred_tk,
           issue_pred_pc, issue_bht_idx, issue_ghr
  );
endinterface

// File: rtl/fetch_unit_bp_ras.sv
// rtl/fetch_unit_bp_ras.sv - circular return-address stack, oldest entry overwritten on overflow
module bp_ras #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);

  logic [31:0] stack [RAS_DEPTH];
  logic [PW-1:0] sp;
  logic [PW:0]   cnt;

  assign top   = stack[sp - 1'b1];
  assign empty = (cnt == '0);

  // Pointer and occupancy; flush only forgets entries, the pointer may stay anywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (en) begin
      if (flush) begin
        cnt <= '0;
      end else if (push) begin
        sp <= sp + 1'b1;
        if (cnt != FULL_CNT) cnt <= cnt + 1'b1;
      end else if (pop) begin
        sp  <= sp - 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Entry storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (en && !flush && push) stack[sp] <= push_addr;
  end
endmodule

// File: rtl/fetch_unit_bp.sv
// rtl/fetch_unit_bp.sv - fetch stage with bimodal/gshare BHT and return-address stack
module fetch_unit_bp
  import fetch_unit_bp_pkg::*;
#(
  parameter int          BHT_IDX_W = 5,
  parameter int          CNT_W     = 2,
  parameter int          GHR_W     = 0,
  parameter int          RAS_DEPTH = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic             clk,
  input logic             rst,
  fetch_unit_bp_if.master bus
);
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam int BHT_N = 2 ** BHT_IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [31:0]      pc;
  fetch_state_e     state;
  logic [GW-1:0]    ghr;
  logic [CNT_W-1:0] bht [BHT_N];

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  assign ins = bus.icache_ins;
  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign rs1 = ins[19:15];

  assign bus.icache_addr = pc;

  // ghr stays zero in bimodal mode, so the XOR degenerates to the plain PC index
  logic [BHT_IDX_W-1:0] idx;
  assign idx = pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr);

  logic fire;
  assign fire = (state == ST_FETCH) && bus.icache_hit &&
                !bus.rs_full && !bus.rob_full && !bus.lsb_full;

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc + 32'd4;

  logic [31:0] ras_top;
  logic        ras_empty;

  logic [31:0]   nxt_pc;
  logic          nxt_tk;
  logic          nxt_wait;
  logic          ras_push;
  logic          ras_pop;
  logic [GW-1:0] nxt_ghr;

  // Predecode the fetched word and form the predicted next PC
  always_comb begin
    nxt_pc   = pc_plus4;
    nxt_tk   = 1'b0;
    nxt_wait = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    nxt_ghr  = ghr;
    case (opc)
      OPC_BRANCH: begin
        nxt_tk = bht[idx][CNT_W-1];
        if (nxt_tk) nxt_pc = pc + imm_b(ins);
        if (GHR_W > 0) nxt_ghr = (ghr << 1) | GW'(nxt_tk);
      end
      OPC_JAL: begin
        nxt_pc   = pc + imm_j(ins);
        nxt_tk   = 1'b1;
        ras_push = is_link(rd);
      end
      OPC_JALR: begin
        if ((rd == 5'd0) && is_link(rs1) && !ras_empty) begin
          nxt_pc  = ras_top;
          nxt_tk  = 1'b1;
          ras_pop = 1'b1;
        end else begin
          nxt_wait = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC, redirect FSM and the registered issue slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc                <= RESET_PC;
      state             <= ST_FETCH;
      ghr               <= '0;
      bus.issue_en      <= 1'b0;
      bus.issue_pc      <= '0;
      bus.issue_ins     <= '0;
      bus.issue_pred_tk <= 1'b0;
      bus.issue_pred_pc <= '0;
      bus.issue_bht_idx <= '0;
      bus.issue_ghr     <= '0;
    end else if (bus.rdy) begin
      if (bus.clear) begin
        pc           <= bus.new_pc;
        state        <= ST_FETCH;
        bus.issue_en <= 1'b0;
        if (GHR_W > 0) ghr <= bus.clear_ghr;
      end else if (fire) begin
        bus.issue_en      <= 1'b1;
        bus.issue_pc      <= pc;
        bus.issue_ins     <= ins;
        bus.issue_pred_tk <= nxt_tk;
        bus.issue_pred_pc <= nxt_pc;
        bus.issue_bht_idx <= idx;
        bus.issue_ghr     <= ghr;
        ghr               <= nxt_ghr;
        if (nxt_wait) state <= ST_WAIT_RDR;
        else          pc    <= nxt_pc;
      end else begin
        bus.issue_en <= 1'b0;
      end
    end
  end

  // Commit-time counter training; a same-cycle lookup sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= CNT_INIT;
    end else if (bus.rdy && bus.upt_en) begin
      if (bus.upt_taken) begin
        if (bht[bus.upt_idx] != CNT_MAX) bht[bus.upt_idx] <= bht[bus.upt_idx] + 1'b1;
      end else begin
        if (bht[bus.upt_idx] != '0) bht[bus.upt_idx] <= bht[bus.upt_idx] - 1'b1;
      end
    end
  end

  bp_ras #(
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.rdy),
    .flush    (bus.clear),
    .push     (fire && ras_push),
    .pop      (fire && ras_pop),
    .push_addr(pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty)
  );
endmodule

// File: tb/tb_fetch_unit_bp.sv
// tb/tb_fetch_unit_bp.sv - bimodal and gshare/small-RAS instances against a list-based reference model
module tb_fetch_unit_bp;

  localparam int K_OTH  = 0;
  localparam int K_BR   = 1;
  localparam int K_JAL  = 2;
  localparam int K_JALR = 3;

  logic clk = 1'b0;
  logic rst;
  logic rdy, hit, rs_full, rob_full, lsb_full, clear, upt_en, upt_taken;
  logic [31:0] ins, new_pc;
  logic [2:0]  clr_ghr;
  logic [4:0]  upt_idx;

  int          cur_kind;
  int          cur_imm;
  logic [4:0]  cur_rd;
  logic [4:0]  cur_rs1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit_bp_if #(.BHT_IDX_W(5), .GHR_W(0)) bus0 ();
  fetch_unit_bp_if #(.BHT_IDX_W(5), .GHR_W(3)) bus1 ();

  assign bus0.rdy = rdy;          assign bus1.rdy = rdy;
  assign bus0.icache_hit = hit;   assign bus1.icache_hit = hit;
  assign bus0.icache_ins = ins;   assign bus1.icache_ins = ins;
  assign bus0.rs_full = rs_full;  assign bus1.rs_full = rs_full;
  assign bus0.rob_full = rob_full; assign bus1.rob_full = rob_full;
  assign bus0.lsb_full = lsb_full; assign bus1.lsb_full = lsb_full;
  assign bus0.clear = clear;      assign bus1.clear = clear;
  assign bus0.new_pc = new_pc;    assign bus1.new_pc = new_pc;
  assign bus0.clear_ghr = clr_ghr[0]; assign bus1.clear_ghr = clr_ghr;
  assign bus0.upt_en = upt_en;    assign bus1.upt_en = upt_en;
  assign bus0.upt_idx = upt_idx;  assign bus1.upt_idx = upt_idx;
  assign bus0.upt_taken = upt_taken; assign bus1.upt_taken = upt_taken;

  fetch_unit_bp #(.BHT_IDX_W(5), .CNT_W(2), .GHR_W(0), .RAS_DEPTH(4), .RESET_PC(32'h0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  fetch_unit_bp #(.BHT_IDX_W(5), .CNT_W(2), .GHR_W(3), .RAS_DEPTH(2), .RESET_PC(32'h1000))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  // reference model state, one slot per instance
  int          P_GHR [2] = '{0, 3};
  int          P_DEP [2] = '{4, 2};
  logic [31:0] P_RST [2] = '{32'h0, 32'h1000};

  logic [31:0] m_pc   [2];
  bit          m_wait [2];
  int          m_ghr  [2];
  int          m_bht  [2][32];
  logic [31:0] m_ras  [2][8];
  int          m_n    [2];

  bit          x_en  [2];
  logic [31:0] x_pc  [2];
  logic [31:0] x_ins [2];
  bit          x_tk  [2];
  logic [31:0] x_ppc [2];
  int          x_idx [2];
  int          x_ghr [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = P_RST[k]; m_wait[k] = 0; m_ghr[k] = 0; m_n[k] = 0;
      for (int i = 0; i < 32; i++) m_bht[k][i] = 2;
      x_en[k] = 0; x_pc[k] = 0; x_ins[k] = 0; x_tk[k] = 0; x_ppc[k] = 0; x_idx[k] = 0; x_ghr[k] = 0;
    end
  endtask

  task automatic ras_push(input int k, input logic [31:0] a);
    if (m_n[k] == P_DEP[k]) begin
      for (int i = 0; i < P_DEP[k] - 1; i++) m_ras[k][i] = m_ras[k][i+1];
      m_ras[k][P_DEP[k]-1] = a;
    end else begin
      m_ras[k][m_n[k]] = a;
      m_n[k]++;
    end
  endtask

  task automatic model_step(input int k);
    logic [31:0] npc;
    bit tk;
    int idx;
    if (!rdy) return;
    idx = int'((m_pc[k] >> 2) & 32'd31) ^ m_ghr[k];
    if (clear) begin
      m_pc[k] = new_pc; x_en[k] = 0; m_n[k] = 0; m_wait[k] = 0;
      m_ghr[k] = (P_GHR[k] > 0) ? int'(clr_ghr) : 0;
    end else if (!m_wait[k] && hit && !rs_full && !rob_full && !lsb_full) begin
      x_en[k] = 1; x_pc[k] = m_pc[k]; x_ins[k] = ins; x_idx[k] = idx; x_ghr[k] = m_ghr[k];
      tk = 0;
      npc = m_pc[k] + 32'd4;
      case (cur_kind)
        K_BR: begin
          tk = (m_bht[k][idx] >= 2);
          if (tk) npc = m_pc[k] + 32'(cur_imm);
          if (P_GHR[k] > 0) m_ghr[k] = ((m_ghr[k] << 1) | int'(tk)) & ((1 << P_GHR[k]) - 1);
        end
        K_JAL: begin
          tk = 1;
          npc = m_pc[k] + 32'(cur_imm);
          if (cur_rd == 5'd1 || cur_rd == 5'd5) ras_push(k, m_pc[k] + 32'd4);
        end
        K_JALR: begin
          if (cur_rd == 5'd0 && (cur_rs1 == 5'd1 || cur_rs1 == 5'd5) && m_n[k] > 0) begin
            tk = 1;
            m_n[k]--;
            npc = m_ras[k][m_n[k]];
          end else begin
            m_wait[k] = 1;
          end
        end
        default: ;
      endcase
      x_tk[k] = tk;
      x_ppc[k] = npc;
      if (!m_wait[k]) m_pc[k] = npc;
    end else begin
      x_en[k] = 0;
    end
    if (upt_en) begin
      if (upt_taken) m_bht[k][upt_idx] = (m_bht[k][upt_idx] < 3) ? m_bht[k][upt_idx] + 1 : 3;
      else           m_bht[k][upt_idx] = (m_bht[k][upt_idx] > 0) ? m_bht[k][upt_idx] - 1 : 0;
    end
  endtask

  task automatic cmp_inst(input int k, input logic en, input logic [31:0] addr, input logic [31:0] pc,
                          input logic [31:0] w, input logic tk, input logic [31:0] ppc,
                          input logic [4:0] idx, input logic [2:0] ghr);
    chk($sformatf("k%0d_addr", k), addr, m_pc[k]);
    chk($sformatf("k%0d_en", k), 32'(en), 32'(x_en[k]));
    chk($sformatf("k%0d_pc", k), pc, x_pc[k]);
    chk($sformatf("k%0d_ins", k), w, x_ins[k]);
    chk($sformatf("k%0d_tk", k), 32'(tk), 32'(x_tk[k]));
    chk($sformatf("k%0d_ppc", k), ppc, x_ppc[k]);
    chk($sformatf("k%0d_idx", k), 32'(idx), 32'(x_idx[k]));
    chk($sformatf("k%0d_ghr", k), 32'(ghr), 32'(x_ghr[k]));
  endtask

  task automatic compare_all();
    cmp_inst(0, bus0.issue_en, bus0.icache_addr, bus0.issue_pc, bus0.issue_ins, bus0.issue_pred_tk,
             bus0.issue_pred_pc, bus0.issue_bht_idx, 3'(bus0.issue_ghr));
    cmp_inst(1, bus1.issue_en, bus1.icache_addr, bus1.issue_pc, bus1.issue_ins, bus1.issue_pred_tk,
             bus1.issue_pred_pc, bus1.issue_bht_idx, bus1.issue_ghr);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  task automatic set_oth(input logic [31:0] w);
    hit = 1'b1; ins = w; cur_kind = K_OTH;
  endtask

  task automatic set_br(input int imm);
    hit = 1'b1; ins = enc_b(32'(imm)); cur_kind = K_BR; cur_imm = imm;
  endtask

  task automatic set_jal(input logic [4:0] rd, input int imm);
    hit = 1'b1; ins = enc_j(rd, 32'(imm)); cur_kind = K_JAL; cur_imm = imm; cur_rd = rd;
  endtask

  task automatic set_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    hit = 1'b1; ins = enc_jalr(rd, rs1); cur_kind = K_JALR; cur_rd = rd; cur_rs1 = rs1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd5;
      2: return 5'd0;
      default: return 5'd7;
    endcase
  endfunction

  task automatic rand_ins();
    int r;
    logic [31:0] w;
    logic [6:0] opl [4];
    opl = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0110111};
    r = int'($urandom_range(0, 9));
    if (r < 3) set_br((int'($urandom_range(0, 64)) - 32) * 2);
    else if (r < 5) set_jal(pick_reg(), (int'($urandom_range(0, 64)) - 32) * 4);
    else if (r < 7) set_jalr(($urandom_range(0, 3) == 0) ? 5'd3 : 5'd0, pick_reg());
    else begin
      w = $urandom;
      w[6:0] = opl[$urandom_range(0, 3)];
      set_oth(w);
    end
    hit = ($urandom_range(0, 4) != 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; hit = 1'b0; ins = 32'h13; rs_full = 1'b0; rob_full = 1'b0; lsb_full = 1'b0;
    clear = 1'b0; new_pc = 32'h0; clr_ghr = 3'd0; upt_en = 1'b0; upt_idx = 5'd0; upt_taken = 1'b0;
    cur_kind = K_OTH; cur_imm = 0; cur_rd = 5'd0; cur_rs1 = 5'd0;
    model_reset();
    #1;
    chk("rst_addr0", bus0.icache_addr, 32'h0);
    chk("rst_addr1", bus1.icache_addr, 32'h1000);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // straight-line ADDI stream
    set_oth(32'h0000_0013);
    tick(); chk("t1_en", 32'(bus0.issue_en), 32'd1); chk("t1_pc0", bus0.issue_pc, 32'h0);
    tick(); chk("t1_pc4", bus0.issue_pc, 32'h4);
    tick(); chk("t1_pc8", bus0.issue_pc, 32'h8);

    // fresh counter predicts taken, training flips it
    hit = 1'b0; clear = 1'b1; new_pc = 32'h20; tick(); clear = 1'b0;
    set_br(16); tick();
    chk("t2_tk", 32'(bus0.issue_pred_tk), 32'd1); chk("t2_ppc", bus0.issue_pred_pc, 32'h30);
    hit = 1'b0; upt_en = 1'b1; upt_idx = 5'd8; upt_taken = 1'b0; tick();
    set_br(16); clear = 1'b1; new_pc = 32'h20; tick();
    chk("t5_en", 32'(bus0.issue_en), 32'd0); chk("t5_addr", bus0.icache_addr, 32'h20);
    clear = 1'b0; upt_en = 1'b0; tick();
    chk("t2_nt", 32'(bus0.issue_pred_tk), 32'd0); chk("t2_ppc24", bus0.issue_pred_pc, 32'h24);
    clear = 1'b1; new_pc = 32'h20; upt_en = 1'b1; upt_taken = 1'b1; tick();
    clear = 1'b0; upt_en = 1'b0; tick();
    chk("t5_cnt", 32'(bus0.issue_pred_tk), 32'd0);

    // backpressure holds the PC
    set_oth(32'h0000_0013); rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_en", 32'(bus0.issue_en), 32'd0); chk("t3_addr", bus0.icache_addr, 32'h24);
    end
    rob_full = 1'b0; tick(); chk("t3_pc", bus0.issue_pc, 32'h24);

    // call/return and the empty-stack stall
    hit = 1'b0; clear = 1'b1; new_pc = 32'h40; tick(); clear = 1'b0;
    set_jal(5'd1, 32'h100); tick(); chk("t4_jal", bus0.issue_pred_pc, 32'h140);
    set_jalr(5'd0, 5'd1); tick();
    chk("t4_ret", bus0.issue_pred_pc, 32'h44); chk("t4_rtk", 32'(bus0.issue_pred_tk), 32'd1);
    tick(); chk("t4_etk", 32'(bus0.issue_pred_tk), 32'd0); chk("t4_eppc", bus0.issue_pred_pc, 32'h48);
    set_oth(32'h0000_0013);
    tick(); chk("t4_wait", 32'(bus0.issue_en), 32'd0);
    tick(); chk("t4_hold", bus0.icache_addr, 32'h44);

    // overflow of the two-entry stack
    hit = 1'b0; clear = 1'b1; new_pc = 32'h40; tick(); clear = 1'b0;
    set_jal(5'd1, 8); tick(); tick(); tick();
    set_jalr(5'd0, 5'd1);
    tick(); chk("t6_r1", bus1.issue_pred_pc, 32'h54);
    tick(); chk("t6_r2", bus1.issue_pred_pc, 32'h4c);
    tick(); chk("t6_r3tk", 32'(bus1.issue_pred_tk), 32'd0); chk("t6_r3d", bus0.issue_pred_pc, 32'h44);
    set_oth(32'h0000_0013); tick();
    mid_reset();
    chk("t6_addr", bus0.icache_addr, 32'h0); chk("t6_en", 32'(bus1.issue_en), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_ins();
      rdy       = ($urandom_range(0, 9) != 0);
      rs_full   = ($urandom_range(0, 9) == 0);
      rob_full  = ($urandom_range(0, 9) == 0);
      lsb_full  = ($urandom_range(0, 9) == 0);
      clear     = ($urandom_range(0, 11) == 0);
      new_pc    = 32'($urandom_range(0, 1023)) << 2;
      clr_ghr   = 3'($urandom_range(0, 7));
      upt_en    = ($urandom_range(0, 2) == 0);
      upt_idx   = 5'($urandom_range(0, 31));
      upt_taken = 1'($urandom_range(0, 1));
      if (c % 1000 == 999) mid_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
